ahb_wb_bridge: RTL

//  AHB-Lite slave to Wishbone B4 classic master bridge with real wait states, byte lanes,

---
 rtl/ahb_wb_pkg.sv | 73 +++++++
 rtl/ahb_wb_sel_gen.sv | 31 +++
 rtl/ahb_wb_bridge.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_wb_pkg.sv
// Shared encodings, FSM states and burst helpers for the AHB-Lite to
// Wishbone bridge.
package ahb_wb_pkg;

    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_ACTIVE,
        ST_RESP_OK,
        ST_BURST_HOLD,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Zero marks an undefined-length transfer (SINGLE or INCR).
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        case (hburst)
            HBURST_SINGLE, HBURST_INCR:   len = 5'd0;
            HBURST_WRAP4, HBURST_INCR4:   len = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd0;
        endcase
        return len;
    endfunction

    function automatic logic [1:0] burst_bte(input logic [2:0] hburst);
        logic [1:0] bte;
        case (hburst)
            HBURST_WRAP4:  bte = BTE_WRAP4;
            HBURST_WRAP8:  bte = BTE_WRAP8;
            HBURST_WRAP16: bte = BTE_WRAP16;
            default:       bte = BTE_LINEAR;
        endcase
        return bte;
    endfunction

    // cnt is the number of beats left including the one being issued.
    function automatic logic [2:0] beat_cti(input logic [4:0] cnt);
        logic [2:0] cti;
        if (cnt == 5'd0) begin
            cti = CTI_CLASSIC;
        end else if (cnt == 5'd1) begin
            cti = CTI_EOB;
        end else begin
            cti = CTI_INCR;
        end
        return cti;
    endfunction

endpackage

// File: rtl/ahb_wb_sel_gen.sv
// Byte-lane select generation from HSIZE and the low address bits,
// little-endian, with an oversize-transfer flag.
module ahb_wb_sel_gen
    import ahb_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              hsize,
    input  logic [2:0]              addr_lo,
    output logic [DATA_WIDTH/8-1:0] sel,
    output logic                    size_err
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [2:0] LANE_MASK = 3'(NB - 1);

    logic [2:0] offset;

    // A lane is selected when it falls in the same size-aligned block
    // as the addressed byte.
    always_comb begin
        offset   = addr_lo & LANE_MASK;
        size_err = hsize > 3'(OFFW);
        sel      = '0;
        for (int i = 0; i < NB; i++) begin
            sel[i] = !size_err && ((3'(i) >> hsize) == (offset >> hsize));
        end
    end

endmodule

// File: rtl/ahb_wb_bridge.sv
// AHB-Lite slave to Wishbone B4 classic master bridge with wait states,
// byte lanes, CTI/BTE burst tagging and two-cycle ERROR responses.
module ahb_wb_bridge
    import ahb_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [DATA_WIDTH-1:0]   wb_dat_w,
    output logic [2:0]              wb_cti,
    output logic [1:0]              wb_bte,
    input  logic [DATA_WIDTH-1:0]   wb_dat_r,
    input  logic                    wb_ack,
    input  logic                    wb_err
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    state_t                state_q, state_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [NB-1:0]         sel_q, sel_d;
    logic [2:0]            cti_q, cti_d;
    logic [1:0]            bte_q, bte_d;
    logic [4:0]            beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;

    logic [NB-1:0] sel_c;
    logic          size_err;
    logic          capture;
    logic          is_seq;
    logic          can_accept;
    logic          timeout_hit;
    logic [4:0]    cap_cnt;

    ahb_wb_sel_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sel_gen (
        .hsize   (HSIZE),
        .addr_lo (HADDR[2:0]),
        .sel     (sel_c),
        .size_err(size_err)
    );

    assign is_seq  = HTRANS == HTRANS_SEQ;
    assign capture = HSEL && HREADY
                     && (HTRANS == HTRANS_NONSEQ || is_seq);

    // A SEQ beat continues the running count; NONSEQ reloads it.
    assign cap_cnt = is_seq
                     ? ((beat_cnt_q != 5'd0) ? beat_cnt_q - 5'd1 : 5'd0)
                     : burst_len(HBURST);

    assign timeout_hit = (TIMEOUT_CYCLES != 0)
                         && (int'(to_cnt_q) >= TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        cti_d       = cti_q;
        bte_d       = bte_q;
        beat_cnt_d  = beat_cnt_q;
        to_cnt_d    = to_cnt_q;
        can_accept  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                can_accept = 1'b1;
            end
            ST_WB_ACTIVE: begin
                if (wb_err || timeout_hit) begin
                    state_d     = ST_ERR1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    hreadyout_d = 1'b0;
                    hresp_d     = 1'b1;
                    beat_cnt_d  = '0;
                    cti_d       = CTI_CLASSIC;
                    bte_d       = BTE_LINEAR;
                end else if (wb_ack) begin
                    state_d     = ST_RESP_OK;
                    stb_d       = 1'b0;
                    cyc_d       = beat_cnt_q > 5'd1;
                    hreadyout_d = 1'b1;
                    hresp_d     = 1'b0;
                    if (!we_q) begin
                        hrdata_d = wb_dat_r;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_RESP_OK, ST_BURST_HOLD: begin
                can_accept = 1'b1;
                // BUSY inside a fixed burst parks the cycle with stb low.
                if (HSEL && HTRANS == HTRANS_BUSY
                    && (state_q == ST_BURST_HOLD || beat_cnt_q > 5'd1)) begin
                    state_d = ST_BURST_HOLD;
                    cyc_d   = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    cyc_d      = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            ST_ERR1: begin
                state_d     = ST_ERR2;
                hreadyout_d = 1'b1;
            end
            ST_ERR2: begin
                can_accept = 1'b1;
                state_d    = ST_IDLE;
                hresp_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (can_accept && capture) begin
            if (size_err) begin
                state_d     = ST_ERR1;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                hreadyout_d = 1'b0;
                hresp_d     = 1'b1;
                beat_cnt_d  = '0;
                cti_d       = CTI_CLASSIC;
                bte_d       = BTE_LINEAR;
            end else begin
                state_d     = ST_WB_ACTIVE;
                cyc_d       = 1'b1;
                stb_d       = 1'b1;
                we_d        = HWRITE;
                adr_d       = HADDR;
                sel_d       = sel_c;
                beat_cnt_d  = cap_cnt;
                cti_d       = beat_cti(cap_cnt);
                bte_d       = (cap_cnt != 5'd0) ? burst_bte(HBURST) : BTE_LINEAR;
                to_cnt_d    = '0;
                hreadyout_d = 1'b0;
                hresp_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            cti_q       <= CTI_CLASSIC;
            bte_q       <= BTE_LINEAR;
            beat_cnt_q  <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            cti_q       <= cti_d;
            bte_q       <= bte_d;
            beat_cnt_q  <= beat_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign wb_cyc    = cyc_q;
    assign wb_stb    = stb_q;
    assign wb_we     = we_q;
    assign wb_adr    = adr_q;
    assign wb_sel    = sel_q;
    assign wb_cti    = cti_q;
    assign wb_bte    = bte_q;
    assign wb_dat_w  = HWDATA;

endmodule
